// File: rtl/fault_shutdown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fault_shutdown_ctrl_pkg
// Shared definitions for the laser fault shutdown controller and the I2C
// status path (i2c_slave_top): FSM state encoding, fault vector bit indices
// and counter widths.
// -----------------------------------------------------------------------------
package fault_shutdown_ctrl_pkg;

  // Encoding is visible to software through the I2C status register.
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2,
    ST_HOLDOFF  = 2'd3
  } fsc_state_e;

  // Fault vector bit order {peak, rate, upper, lower}.
  localparam int FAULT_LOWER = 0;
  localparam int FAULT_UPPER = 1;
  localparam int FAULT_RATE  = 2;
  localparam int FAULT_PEAK  = 3;
  localparam int FAULT_W     = 4;

  localparam int HOLDOFF_CNT_W = 20;
  localparam int TRIP_CNT_W    = 8;

endpackage

// File: rtl/fault_shutdown_ctrl_holdoff_timer.sv
// -----------------------------------------------------------------------------
// holdoff_timer
// Counts quiet cycles before the shutdown controller may re-arm.
//   clk       : system clock
//   rst       : asynchronous active-high reset, clears the count
//   count_en  : advance the count this cycle
//   restart   : force the count back to zero (wins over count_en)
//   done      : high on the cycle whose edge completes HOLDOFF_CYCLES counts
// -----------------------------------------------------------------------------
module holdoff_timer
  import fault_shutdown_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic restart,
  output logic done
);

  localparam logic [HOLDOFF_CNT_W-1:0] LAST_CNT = HOLDOFF_CNT_W'(HOLDOFF_CYCLES - 1);

  logic [HOLDOFF_CNT_W-1:0] cnt_q;
  logic [HOLDOFF_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the FSM leaves HOLDOFF on the very edge the count
  // reaches HOLDOFF_CYCLES, not one cycle later.
  assign done = count_en && !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/fault_shutdown_ctrl.sv
// -----------------------------------------------------------------------------
// fault_shutdown_ctrl
// Trips the amplifier shutdown on any limit fault, latches fault causes,
// accepts a software clear only once faults are gone, then requires a quiet
// holdoff (no laser pulses, no faults) before re-arming.
//   clk, rst                       : clock, async active-high reset
//   pulse_lower/upper_limit_fail,
//   rate_lower_limit_fail,
//   power_peak_current_limit_fail  : fault inputs
//   enable_error_check             : low blocks new trips (ARMED->DISABLED)
//   clear_fail                     : one-cycle clear request
//   laser_pulse                    : laser drive pulse, restarts holdoff
//   laser_pwr_en_req               : software power enable request
//   ta_shutdown, laser_pwr_en      : registered outputs
//   fault_first, fault_latched     : {peak, rate, upper, lower}
//   trip_count                     : saturating trip counter
//   state                          : encoded FSM state
// -----------------------------------------------------------------------------
module fault_shutdown_ctrl
  import fault_shutdown_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_lower_limit_fail,
  input  logic                  pulse_upper_limit_fail,
  input  logic                  rate_lower_limit_fail,
  input  logic                  power_peak_current_limit_fail,
  input  logic                  enable_error_check,
  input  logic                  clear_fail,
  input  logic                  laser_pulse,
  input  logic                  laser_pwr_en_req,
  output logic                  ta_shutdown,
  output logic                  laser_pwr_en,
  output logic [FAULT_W-1:0]    fault_first,
  output logic [FAULT_W-1:0]    fault_latched,
  output logic [TRIP_CNT_W-1:0] trip_count,
  output logic [1:0]            state
);

  fsc_state_e state_q, state_d;

  logic [FAULT_W-1:0]    faults;
  logic                  any_fault;
  logic                  clear_ok;
  logic                  tmr_done;
  logic                  tmr_count_en;
  logic                  tmr_restart;
  logic                  trip_entry;

  logic                  ta_shutdown_q, ta_shutdown_d;
  logic                  laser_pwr_en_q, laser_pwr_en_d;
  logic [FAULT_W-1:0]    fault_first_q, fault_first_d;
  logic [FAULT_W-1:0]    fault_latched_q, fault_latched_d;
  logic [TRIP_CNT_W-1:0] trip_count_q, trip_count_d;

  always_comb begin
    faults              = '0;
    faults[FAULT_LOWER] = pulse_lower_limit_fail;
    faults[FAULT_UPPER] = pulse_upper_limit_fail;
    faults[FAULT_RATE]  = rate_lower_limit_fail;
    faults[FAULT_PEAK]  = power_peak_current_limit_fail;
  end

  assign any_fault = |faults;
  assign clear_ok  = (state_q == ST_TRIPPED) && clear_fail && !any_fault;

  // Counter is held at zero outside HOLDOFF, so every HOLDOFF entry starts a
  // full quiet period.
  assign tmr_restart  = (state_q != ST_HOLDOFF) || laser_pulse;
  assign tmr_count_en = (state_q == ST_HOLDOFF) && !laser_pulse && !any_fault;

  holdoff_timer #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff_timer (
    .clk     (clk),
    .rst     (rst),
    .count_en(tmr_count_en),
    .restart (tmr_restart),
    .done    (tmr_done)
  );

  // State register; reset parks in HOLDOFF so power-up needs a full holdoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLDOFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A fault in ARMED beats a simultaneous clear or enable drop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISABLED: if (enable_error_check) state_d = ST_ARMED;
      ST_ARMED: begin
        if (any_fault)                state_d = ST_TRIPPED;
        else if (!enable_error_check) state_d = ST_DISABLED;
      end
      ST_TRIPPED: if (clear_ok) state_d = ST_HOLDOFF;
      ST_HOLDOFF: begin
        if (any_fault)     state_d = ST_TRIPPED;
        else if (tmr_done) state_d = ST_ARMED;
      end
      default: state_d = ST_HOLDOFF;
    endcase
  end

  // Output next values, derived from state_d so registered outputs line up
  // with the state register.
  always_comb begin
    trip_entry      = (state_d == ST_TRIPPED) && (state_q != ST_TRIPPED);
    ta_shutdown_d   = (state_d == ST_TRIPPED) || (state_d == ST_HOLDOFF);
    laser_pwr_en_d  = laser_pwr_en_req &&
                      ((state_d == ST_ARMED) || (state_d == ST_DISABLED));
    fault_first_d   = trip_entry ? faults : fault_first_q;
    fault_latched_d = clear_ok ? '0 : (fault_latched_q | faults);
    trip_count_d    = trip_count_q;
    if (trip_entry && (trip_count_q != {TRIP_CNT_W{1'b1}})) begin
      trip_count_d = trip_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_shutdown_q   <= 1'b1;
      laser_pwr_en_q  <= 1'b0;
      fault_first_q   <= '0;
      fault_latched_q <= '0;
      trip_count_q    <= '0;
    end else begin
      ta_shutdown_q   <= ta_shutdown_d;
      laser_pwr_en_q  <= laser_pwr_en_d;
      fault_first_q   <= fault_first_d;
      fault_latched_q <= fault_latched_d;
      trip_count_q    <= trip_count_d;
    end
  end

  assign ta_shutdown   = ta_shutdown_q;
  assign laser_pwr_en  = laser_pwr_en_q;
  assign fault_first   = fault_first_q;
  assign fault_latched = fault_latched_q;
  assign trip_count    = trip_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_fault_shutdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fault_shutdown_ctrl
// Directed bench for fault_shutdown_ctrl with HOLDOFF_CYCLES = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fault_shutdown_ctrl;

  localparam int unsigned HC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       lower, upper, rate, peak;
  logic       enable_error_check, clear_fail, laser_pulse, laser_pwr_en_req;
  logic       ta_shutdown, laser_pwr_en;
  logic [3:0] fault_first, fault_latched;
  logic [7:0] trip_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int exp_tc = 0;

  fault_shutdown_ctrl #(.HOLDOFF_CYCLES(HC)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .pulse_lower_limit_fail       (lower),
    .pulse_upper_limit_fail       (upper),
    .rate_lower_limit_fail        (rate),
    .power_peak_current_limit_fail(peak),
    .enable_error_check           (enable_error_check),
    .clear_fail                   (clear_fail),
    .laser_pulse                  (laser_pulse),
    .laser_pwr_en_req             (laser_pwr_en_req),
    .ta_shutdown                  (ta_shutdown),
    .laser_pwr_en                 (laser_pwr_en),
    .fault_first                  (fault_first),
    .fault_latched                (fault_latched),
    .trip_count                   (trip_count),
    .state                        (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clear (faults already low) then ride out a quiet holdoff back to ARMED.
  task automatic clear_and_rearm();
    clear_fail = 1'b1; step(); clear_fail = 1'b0;
    repeat (HC) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (state !== 2'd3)         begin errors++; $display("FAIL reset_state got %0d exp 3", state); end
    checks++; if (ta_shutdown !== 1'b1)   begin errors++; $display("FAIL reset_ta got %b exp 1", ta_shutdown); end
    checks++; if (laser_pwr_en !== 1'b0)  begin errors++; $display("FAIL reset_pwr got %b exp 0", laser_pwr_en); end
    checks++; if (fault_first !== 4'h0)   begin errors++; $display("FAIL reset_ff got %b exp 0000", fault_first); end
    checks++; if (fault_latched !== 4'h0) begin errors++; $display("FAIL reset_fl got %b exp 0000", fault_latched); end
    checks++; if (trip_count !== 8'd0)    begin errors++; $display("FAIL reset_tc got %0d exp 0", trip_count); end
  endtask

  task automatic test_holdoff_release();
    rst = 1'b0;
    for (int i = 1; i < int'(HC); i++) begin
      step();
      checks++; if (ta_shutdown !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL holdoff_cyc%0d ta %b state %0d exp ta 1 state 3", i, ta_shutdown, state); end
    end
    step();
    checks++; if (state !== 2'd1)        begin errors++; $display("FAIL release_state got %0d exp 1", state); end
    checks++; if (ta_shutdown !== 1'b0)  begin errors++; $display("FAIL release_ta got %b exp 0", ta_shutdown); end
    checks++; if (laser_pwr_en !== 1'b1) begin errors++; $display("FAIL release_pwr got %b exp 1", laser_pwr_en); end
  endtask

  task automatic test_trip();
    rate = 1'b1; step(); rate = 1'b0;
    exp_tc++;
    checks++; if (ta_shutdown !== 1'b1)     begin errors++; $display("FAIL trip_ta got %b exp 1", ta_shutdown); end
    checks++; if (state !== 2'd2)           begin errors++; $display("FAIL trip_state got %0d exp 2", state); end
    checks++; if (fault_first !== 4'b0100)  begin errors++; $display("FAIL trip_ff got %b exp 0100", fault_first); end
    checks++; if (trip_count !== 8'(exp_tc)) begin errors++; $display("FAIL trip_tc got %0d exp %0d", trip_count, exp_tc); end
    checks++; if (laser_pwr_en !== 1'b0)    begin errors++; $display("FAIL trip_pwr got %b exp 0", laser_pwr_en); end
  endtask

  task automatic test_clear();
    upper = 1'b1; step();
    checks++; if (fault_first !== 4'b0100 || fault_latched !== 4'b0110) begin errors++; $display("FAIL clr_latch ff %b fl %b exp 0100 0110", fault_first, fault_latched); end
    clear_fail = 1'b1; step(); clear_fail = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL clr_blocked state %0d exp 2", state); end
    upper = 1'b0; step();
    clear_fail = 1'b1; step(); clear_fail = 1'b0;
    checks++; if (state !== 2'd3)         begin errors++; $display("FAIL clr_state got %0d exp 3", state); end
    checks++; if (fault_latched !== 4'h0) begin errors++; $display("FAIL clr_fl got %b exp 0000", fault_latched); end
    checks++; if (ta_shutdown !== 1'b1)   begin errors++; $display("FAIL clr_ta got %b exp 1", ta_shutdown); end
  endtask

  task automatic test_holdoff_restart();
    repeat (5) step();
    laser_pulse = 1'b1; step(); laser_pulse = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL pulse_state got %0d exp 3", state); end
    for (int i = 1; i < int'(HC); i++) begin
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL restart_cyc%0d state %0d exp 3", i, state); end
    end
    step();
    checks++; if (state !== 2'd1 || ta_shutdown !== 1'b0) begin errors++; $display("FAIL restart_arm state %0d ta %b exp 1 0", state, ta_shutdown); end
  endtask

  task automatic test_fault_in_holdoff();
    peak = 1'b1; step(); peak = 1'b0;
    exp_tc++;
    clear_fail = 1'b1; step(); clear_fail = 1'b0;
    repeat (3) step();
    lower = 1'b1; step(); lower = 1'b0;
    exp_tc++;
    checks++; if (state !== 2'd2)            begin errors++; $display("FAIL hofault_state got %0d exp 2", state); end
    checks++; if (fault_first !== 4'b0001)   begin errors++; $display("FAIL hofault_ff got %b exp 0001", fault_first); end
    checks++; if (trip_count !== 8'(exp_tc)) begin errors++; $display("FAIL hofault_tc got %0d exp %0d", trip_count, exp_tc); end
    clear_and_rearm();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL hofault_rearm state %0d exp 1", state); end
  endtask

  task automatic test_simultaneous();
    lower = 1'b1; peak = 1'b1; step(); lower = 1'b0; peak = 1'b0;
    exp_tc++;
    checks++; if (fault_first !== 4'b1001)   begin errors++; $display("FAIL simul_ff got %b exp 1001", fault_first); end
    checks++; if (trip_count !== 8'(exp_tc)) begin errors++; $display("FAIL simul_tc got %0d exp %0d", trip_count, exp_tc); end
    clear_and_rearm();
    // Fault and clear on the same edge in ARMED: trip wins.
    rate = 1'b1; clear_fail = 1'b1; step(); rate = 1'b0; clear_fail = 1'b0;
    exp_tc++;
    checks++; if (state !== 2'd2 || fault_latched !== 4'b0100) begin errors++; $display("FAIL trip_clr state %0d fl %b exp 2 0100", state, fault_latched); end
    clear_and_rearm();
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 300; k++) begin
      upper = 1'b1; step(); upper = 1'b0;
      if (exp_tc < 255) exp_tc++;
      if (exp_tc >= 254 && exp_tc <= 255 && k < 300) begin
        checks++; if (trip_count !== 8'(exp_tc)) begin errors++; $display("FAIL sat_k%0d got %0d exp %0d", k, trip_count, exp_tc); end
      end
      clear_and_rearm();
    end
    checks++; if (trip_count !== 8'd255)    begin errors++; $display("FAIL sat_final got %0d exp 255", trip_count); end
    checks++; if (fault_first !== 4'b0010) begin errors++; $display("FAIL sat_ff got %b exp 0010", fault_first); end
  endtask

  task automatic test_enable();
    rate = 1'b1; step(); rate = 1'b0;
    enable_error_check = 1'b0;
    repeat (3) step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL en_tripped state %0d exp 2", state); end
    enable_error_check = 1'b1;
    clear_and_rearm();
    enable_error_check = 1'b0; step();
    checks++; if (state !== 2'd0 || laser_pwr_en !== 1'b1) begin errors++; $display("FAIL en_disabled state %0d pwr %b exp 0 1", state, laser_pwr_en); end
    lower = 1'b1; step(); lower = 1'b0;
    checks++; if (state !== 2'd0 || ta_shutdown !== 1'b0) begin errors++; $display("FAIL dis_nofault state %0d ta %b exp 0 0", state, ta_shutdown); end
    checks++; if (fault_latched !== 4'b0001) begin errors++; $display("FAIL dis_fl got %b exp 0001", fault_latched); end
    checks++; if (trip_count !== 8'd255)     begin errors++; $display("FAIL dis_tc got %0d exp 255", trip_count); end
    laser_pwr_en_req = 1'b0; step();
    checks++; if (laser_pwr_en !== 1'b0) begin errors++; $display("FAIL pwr_req_off got %b exp 0", laser_pwr_en); end
    laser_pwr_en_req = 1'b1;
    enable_error_check = 1'b1; step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL en_rearm state %0d exp 1", state); end
  endtask

  task automatic test_reset_midtrip();
    peak = 1'b1; step(); peak = 1'b0;
    rst = 1'b1; #1;
    checks++; if (state !== 2'd3 || trip_count !== 8'd0 || ta_shutdown !== 1'b1) begin errors++; $display("FAIL async_rst state %0d tc %0d ta %b exp 3 0 1", state, trip_count, ta_shutdown); end
    step();
    rst = 1'b0;
    for (int i = 1; i < int'(HC); i++) begin
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL rst_ho_cyc%0d state %0d exp 3", i, state); end
    end
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_rearm state %0d exp 1", state); end
  endtask

  initial begin
    rst = 1'b1;
    lower = 1'b0; upper = 1'b0; rate = 1'b0; peak = 1'b0;
    enable_error_check = 1'b1; clear_fail = 1'b0;
    laser_pulse = 1'b0; laser_pwr_en_req = 1'b1;
    test_reset();
    test_holdoff_release();
    test_trip();
    test_clear();
    test_holdoff_restart();
    test_fault_in_holdoff();
    test_simultaneous();
    test_saturation();
    test_enable();
    test_reset_midtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_shutdown_ctrl.md
FAULT_SHUTDOWN_CTRL -- requirements
Module: fault_shutdown_ctrl

Interface
REQ-001 Parameter: HOLDOFF_CYCLES, 25000, quiet cycles required before re-arm (1 ms at clk_div2 = 25 MHz); legal range 1..2^20-1.
REQ-002 Port: clk  input  1  system clock (clk_div2 domain); all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: pulse_lower_limit_fail  input  1  pulse-width lower-limit fault from limit_check.
REQ-005 Port: pulse_upper_limit_fail  input  1  pulse-width upper-limit fault from limit_check.
REQ-006 Port: rate_lower_limit_fail  input  1  rate fault from limit_check.
REQ-007 Port: power_peak_current_limit_fail  input  1  peak-current fault from power_peak_check_top.
REQ-008 Port: enable_error_check  input  1  static_control[3]; low blocks new trips.
REQ-009 Port: clear_fail  input  1  one-cycle clear request (dynamic_control[0]).
REQ-010 Port: laser_pulse  input  1  laser drive pulse, already synchronous to clk.
REQ-011 Port: laser_pwr_en_req  input  1  software power-enable request (static_control[2]).
REQ-012 Port: ta_shutdown  output  1  registered amplifier shutdown.
REQ-013 Port: laser_pwr_en  output  1  registered gated power enable.
REQ-014 Port: fault_first  output  4  fault(s) causing the current trip, bit order {peak, rate, upper, lower}.
REQ-015 Port: fault_latched  output  4  sticky OR of all faults seen since the last accepted clear, same bit order.
REQ-016 Port: trip_count  output  8  saturating trip counter.
REQ-017 Port: state  output  2  encoded FSM state for the I2C status register.

Function
REQ-018 FSM states SHALL be DISABLED=0, ARMED=1, TRIPPED=2, HOLDOFF=3.
REQ-019 ARMED: any fault input high at edge N SHALL move the FSM to TRIPPED with ta_shutdown=1 and laser_pwr_en=0 visible after edge N (one-cycle latency).
REQ-020 On entry to TRIPPED, fault_first SHALL load all fault bits high at that edge, simultaneous faults included; it holds until the next trip.
REQ-021 fault_latched SHALL OR in every fault input each cycle regardless of state; it clears only when clear_fail is accepted.
REQ-022 trip_count SHALL increment on every entry to TRIPPED and saturate at 255.
REQ-023 TRIPPED: clear_fail with all faults low SHALL be accepted, moving to HOLDOFF and zeroing fault_latched; clear_fail with any fault high SHALL be ignored.
REQ-024 HOLDOFF: a 20-bit counter SHALL count cycles with laser_pulse low and all faults low; laser_pulse high SHALL reset the counter to 0.
REQ-025 HOLDOFF: any fault high SHALL return the FSM to TRIPPED, reload fault_first and increment trip_count.
REQ-026 HOLDOFF: when the count reaches HOLDOFF_CYCLES, the FSM SHALL enter ARMED and ta_shutdown SHALL deassert on that same edge.
REQ-027 ARMED with enable_error_check low and no fault SHALL go to DISABLED; DISABLED with enable_error_check high SHALL go to ARMED.
REQ-028 DISABLED SHALL ignore faults for FSM purposes while still updating fault_latched.
REQ-029 enable_error_check low SHALL NOT release TRIPPED or HOLDOFF.
REQ-030 ta_shutdown SHALL be 1 exactly in TRIPPED and HOLDOFF.
REQ-031 laser_pwr_en SHALL equal laser_pwr_en_req AND (state ARMED or DISABLED), registered.
REQ-032 In ARMED, a fault and clear_fail at the same edge SHALL give a trip; the clear is ignored.

Reset
REQ-033 rst high SHALL asynchronously force state=HOLDOFF, counter=0, ta_shutdown=1, laser_pwr_en=0, fault_first=0, fault_latched=0 and trip_count=0.
REQ-034 Reset asserted mid-trip or mid-holdoff SHALL restart the full holdoff after release, with no shortcut to ARMED.

Structure
REQ-035 The state encoding and the fault bit indices SHALL live in the shared package used by i2c_slave_top.
REQ-036 The holdoff counter SHALL be one sub-module, holdoff_timer (inputs count_en, restart; output done).

Verification
REQ-037 Release rst; hold laser_pulse low, no faults, HOLDOFF_CYCLES=8 -> ta_shutdown=1 for 8 cycles, then state=1 and ta_shutdown=0.
REQ-038 ARMED; pulse rate_lower_limit_fail for 1 cycle -> ta_shutdown=1 next cycle, fault_first=4'b0100, trip_count=1, laser_pwr_en=0.
REQ-039 TRIPPED with upper fault still high; pulse clear_fail -> state stays 2. Drop the fault, pulse clear_fail -> state=3 and fault_latched=0.
REQ-040 HOLDOFF; laser_pulse high at count 5 of 8 -> counter restarts, ARMED only after 8 further quiet cycles.
REQ-041 ARMED; raise lower and peak faults on the same cycle -> fault_first=4'b1001; repeat 300 trips -> trip_count=255.
REQ-042 TRIPPED; drop enable_error_check -> state stays 2. In ARMED, drop it -> state=0, and faults cause no trip while fault_latched still sets.
